// File: rtl/rob_alloc_if.sv
// Decode/ROB/LSQ-facing bundle for the ROB-id and LSQ-slot allocator.
// Latency: n/a (wires only).
// Backpressure: alloc_stall is the only backpressure signal and it goes to decode.
//
// Ports:
//   master -- the pipeline side: decode request, ROB retire/flush, LSQ release.
//   slave  -- the allocator: grant, granted id, stall, head, counts, error flag.
interface rob_alloc_if;
    // decode side
    logic       decode_alloc_req;
    logic       decode_uses_memory;
    logic       alloc_grant;
    logic [7:0] alloc_robid;
    logic       alloc_stall;
    // ROB side
    logic       rob_retire;
    logic [7:0] rob_retire_robid;
    logic       rob_flush;
    logic [7:0] rob_head;
    logic [8:0] rob_count;
    // LSQ side
    logic       lsq_release;
    logic [7:0] lsq_count;
    // status
    logic       alloc_error;

    modport master (
        output decode_alloc_req,
        output decode_uses_memory,
        output rob_retire,
        output rob_retire_robid,
        output rob_flush,
        output lsq_release,
        input  alloc_grant,
        input  alloc_robid,
        input  alloc_stall,
        input  rob_head,
        input  rob_count,
        input  lsq_count,
        input  alloc_error
    );

    modport slave (
        input  decode_alloc_req,
        input  decode_uses_memory,
        input  rob_retire,
        input  rob_retire_robid,
        input  rob_flush,
        input  lsq_release,
        output alloc_grant,
        output alloc_robid,
        output alloc_stall,
        output rob_head,
        output rob_count,
        output lsq_count,
        output alloc_error
    );
endinterface

// File: rtl/rob_alloc.sv
// In-order ROB-id and LSQ-slot allocator between decode and rename.
// Latency: grant/stall/id are combinational (zero cycles); state updates on the next posedge.
// Backpressure: alloc_stall holds decode when the ROB is full, an LSQ slot is needed but none is free, or a flush is in progress.
//
// Ports:
//   clk  -- clock, all state changes on posedge
//   rst  -- asynchronous active-high reset
//   bus  -- rob_alloc_if.slave: decode request/grant, ROB retire/flush/head/count,
//           LSQ release/count, sticky alloc_error
module rob_alloc #(
    parameter int ROB_DEPTH = 64,   // power of two, 2..256
    parameter int LSQ_DEPTH = 16    // 1..255
) (
    input  logic         clk,
    input  logic         rst,
    rob_alloc_if.slave   bus
);

    localparam int         PTR_W    = $clog2(ROB_DEPTH);
    localparam logic [8:0] ROB_FULL = 9'(ROB_DEPTH);
    localparam logic [7:0] LSQ_FULL = 8'(LSQ_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] head_q,      head_d;
    logic [PTR_W-1:0] tail_q,      tail_d;
    logic [8:0]       rob_count_q, rob_count_d;
    logic [7:0]       lsq_count_q, lsq_count_d;
    logic             error_q,     error_d;

    // ------------------------------------------------------------------
    // Per-cycle decisions
    // ------------------------------------------------------------------
    logic rob_full;
    logic lsq_full;
    logic stall;
    logic grant;
    logic grant_mem;
    logic retire_legal;
    logic retire_illegal;
    logic release_legal;
    logic release_illegal;

    assign rob_full = (rob_count_q == ROB_FULL);
    assign lsq_full = (lsq_count_q == LSQ_FULL);

    // Stall is computed from registered counts only: capacity freed by a
    // retire or release this cycle is not visible until the next cycle.
    assign stall = bus.decode_alloc_req &
                   (rob_full | (bus.decode_uses_memory & lsq_full) | bus.rob_flush);
    assign grant     = bus.decode_alloc_req & ~stall;
    assign grant_mem = grant & bus.decode_uses_memory;

    // A retire must name the current head of a non-empty ROB.
    assign retire_legal   = bus.rob_retire && (rob_count_q != 9'd0) &&
                            (bus.rob_retire_robid == 8'(head_q));
    assign retire_illegal = bus.rob_retire & ~retire_legal;

    // A release during flush is dropped outright: the flush empties the LSQ
    // count anyway, so it is neither applied nor treated as an error.
    assign release_legal   = bus.lsq_release & ~bus.rob_flush & (lsq_count_q != 8'd0);
    assign release_illegal = bus.lsq_release & ~bus.rob_flush & (lsq_count_q == 8'd0);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        rob_count_d = rob_count_q;
        lsq_count_d = lsq_count_q;
        error_d     = error_q | retire_illegal | release_illegal;

        // Pointers wrap for free because ROB_DEPTH is a power of two.
        head_d = head_q + PTR_W'(retire_legal);

        if (bus.rob_flush) begin
            // Retire is applied first, so the surviving head is the
            // post-retire head and the ROB restarts empty from there.
            tail_d      = head_d;
            rob_count_d = 9'd0;
            lsq_count_d = 8'd0;
        end else begin
            tail_d      = tail_q + PTR_W'(grant);
            rob_count_d = rob_count_q + 9'(grant) - 9'(retire_legal);
            lsq_count_d = lsq_count_q + 8'(grant_mem) - 8'(release_legal);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            rob_count_q <= '0;
            lsq_count_q <= '0;
            error_q     <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            rob_count_q <= rob_count_d;
            lsq_count_q <= lsq_count_d;
            error_q     <= error_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.alloc_grant = grant;
    assign bus.alloc_stall = stall;
    assign bus.alloc_robid = 8'(tail_q);
    assign bus.rob_head    = 8'(head_q);
    assign bus.rob_count   = rob_count_q;
    assign bus.lsq_count   = lsq_count_q;
    assign bus.alloc_error = error_q;

endmodule

// File: tb/tb_rob_alloc.sv
// Directed self-checking bench for rob_alloc with ROB_DEPTH=4, LSQ_DEPTH=2.
// Inputs are driven just after negedge; outputs are sampled 1 time unit later,
// well away from the posedge at which state commits.
module tb_rob_alloc;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rob_alloc_if bus ();

    rob_alloc #(
        .ROB_DEPTH (4),
        .LSQ_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.decode_alloc_req   = 1'b0;
        bus.decode_uses_memory = 1'b0;
        bus.rob_retire         = 1'b0;
        bus.rob_retire_robid   = 8'd0;
        bus.lsq_release        = 1'b0;
        bus.rob_flush          = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus.alloc_robid !== 8'd0) begin errors++; $display("FAIL reset_robid: got %0d expected 0", bus.alloc_robid); end
        checks++;
        if (bus.rob_head !== 8'd0) begin errors++; $display("FAIL reset_head: got %0d expected 0", bus.rob_head); end
        checks++;
        if (bus.rob_count !== 9'd0 || bus.lsq_count !== 8'd0) begin errors++; $display("FAIL reset_counts: got rob=%0d lsq=%0d expected 0/0", bus.rob_count, bus.lsq_count); end
        checks++;
        if (bus.alloc_grant !== 1'b0 || bus.alloc_stall !== 1'b0 || bus.alloc_error !== 1'b0) begin errors++; $display("FAIL reset_flags: got grant=%b stall=%b err=%b expected 0/0/0", bus.alloc_grant, bus.alloc_stall, bus.alloc_error); end
    endtask

    // Fill the ROB, then exercise retire-from-full with the wrap to id 0.
    task automatic test_fill_and_retire_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.decode_alloc_req = 1'b1;
            #1;
            checks++;
            if (bus.alloc_grant !== 1'b1 || bus.alloc_robid !== 8'(i)) begin errors++; $display("FAIL fill_grant%0d: got grant=%b id=%0d expected 1/%0d", i, bus.alloc_grant, bus.alloc_robid, i); end
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.alloc_stall !== 1'b1 || bus.alloc_grant !== 1'b0 || bus.rob_count !== 9'd4) begin errors++; $display("FAIL full_stall: got stall=%b grant=%b count=%0d expected 1/0/4", bus.alloc_stall, bus.alloc_grant, bus.rob_count); end
        // retire id 0 while full and requesting: no bypass
        bus.rob_retire       = 1'b1;
        bus.rob_retire_robid = 8'd0;
        #1;
        checks++;
        if (bus.alloc_grant !== 1'b0 || bus.alloc_stall !== 1'b1) begin errors++; $display("FAIL retire_no_bypass: got grant=%b stall=%b expected 0/1", bus.alloc_grant, bus.alloc_stall); end
        @(negedge clk);
        bus.rob_retire = 1'b0;
        #1;
        checks++;
        if (bus.alloc_grant !== 1'b1 || bus.alloc_robid !== 8'd0 || bus.rob_head !== 8'd1 || bus.rob_count !== 9'd3) begin errors++; $display("FAIL grant_after_retire: got grant=%b id=%0d head=%0d count=%0d expected 1/0/1/3", bus.alloc_grant, bus.alloc_robid, bus.rob_head, bus.rob_count); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.rob_count !== 9'd4 || bus.alloc_robid !== 8'd1) begin errors++; $display("FAIL refill: got count=%0d tail=%0d expected 4/1", bus.rob_count, bus.alloc_robid); end
    endtask

    task automatic test_lsq();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.decode_alloc_req   = 1'b1;
            bus.decode_uses_memory = 1'b1;
            #1;
            checks++;
            if (bus.alloc_grant !== 1'b1 || bus.alloc_robid !== 8'(i)) begin errors++; $display("FAIL lsq_grant%0d: got grant=%b id=%0d expected 1/%0d", i, bus.alloc_grant, bus.alloc_robid, i); end
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.alloc_stall !== 1'b1 || bus.alloc_grant !== 1'b0 || bus.lsq_count !== 8'd2) begin errors++; $display("FAIL lsq_full_stall: got stall=%b grant=%b lsq=%0d expected 1/0/2", bus.alloc_stall, bus.alloc_grant, bus.lsq_count); end
        bus.decode_uses_memory = 1'b0;
        #1;
        checks++;
        if (bus.alloc_grant !== 1'b1 || bus.alloc_stall !== 1'b0 || bus.alloc_robid !== 8'd2) begin errors++; $display("FAIL nonmem_granted: got grant=%b stall=%b id=%0d expected 1/0/2", bus.alloc_grant, bus.alloc_stall, bus.alloc_robid); end
        // memory request plus release in the same cycle: still stalled
        @(negedge clk);
        bus.decode_uses_memory = 1'b1;
        bus.lsq_release        = 1'b1;
        #1;
        checks++;
        if (bus.alloc_stall !== 1'b1 || bus.rob_count !== 9'd3 || bus.lsq_count !== 8'd2) begin errors++; $display("FAIL release_no_bypass: got stall=%b rob=%0d lsq=%0d expected 1/3/2", bus.alloc_stall, bus.rob_count, bus.lsq_count); end
        @(negedge clk);
        bus.lsq_release = 1'b0;
        #1;
        checks++;
        if (bus.alloc_grant !== 1'b1 || bus.lsq_count !== 8'd1 || bus.alloc_robid !== 8'd3) begin errors++; $display("FAIL grant_after_release: got grant=%b lsq=%0d id=%0d expected 1/1/3", bus.alloc_grant, bus.lsq_count, bus.alloc_robid); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.rob_count !== 9'd4 || bus.lsq_count !== 8'd2 || bus.alloc_error !== 1'b0) begin errors++; $display("FAIL lsq_final: got rob=%0d lsq=%0d err=%b expected 4/2/0", bus.rob_count, bus.lsq_count, bus.alloc_error); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.decode_alloc_req   = 1'b1;
            bus.decode_uses_memory = (i == 0);
        end
        @(negedge clk);
        bus.decode_uses_memory = 1'b0;
        bus.rob_flush          = 1'b1;
        bus.rob_retire         = 1'b1;
        bus.rob_retire_robid   = 8'd0;
        bus.lsq_release        = 1'b1;
        #1;
        checks++;
        if (bus.alloc_stall !== 1'b1 || bus.alloc_grant !== 1'b0 || bus.rob_count !== 9'd3 || bus.lsq_count !== 8'd1) begin errors++; $display("FAIL flush_cycle: got stall=%b grant=%b rob=%0d lsq=%0d expected 1/0/3/1", bus.alloc_stall, bus.alloc_grant, bus.rob_count, bus.lsq_count); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.rob_head !== 8'd1 || bus.alloc_robid !== 8'd1) begin errors++; $display("FAIL flush_ptrs: got head=%0d tail=%0d expected 1/1", bus.rob_head, bus.alloc_robid); end
        checks++;
        if (bus.rob_count !== 9'd0 || bus.lsq_count !== 8'd0 || bus.alloc_error !== 1'b0) begin errors++; $display("FAIL flush_counts: got rob=%0d lsq=%0d err=%b expected 0/0/0", bus.rob_count, bus.lsq_count, bus.alloc_error); end
    endtask

    task automatic test_errors();
        do_reset();
        @(negedge clk);
        bus.decode_alloc_req = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus.rob_retire       = 1'b1;
        bus.rob_retire_robid = 8'd3;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.alloc_error !== 1'b1 || bus.rob_count !== 9'd1 || bus.rob_head !== 8'd0) begin errors++; $display("FAIL bad_retire: got err=%b count=%0d head=%0d expected 1/1/0", bus.alloc_error, bus.rob_count, bus.rob_head); end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.alloc_error !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b expected 1", bus.alloc_error); end
        // illegal release, separately from a clean reset
        do_reset();
        @(negedge clk);
        bus.lsq_release      = 1'b1;
        bus.decode_alloc_req = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.alloc_error !== 1'b1 || bus.lsq_count !== 8'd0 || bus.rob_count !== 9'd1) begin errors++; $display("FAIL bad_release: got err=%b lsq=%0d rob=%0d expected 1/0/1", bus.alloc_error, bus.lsq_count, bus.rob_count); end
    endtask

    // Allocate and retire every cycle: ids wrap 3 -> 0 with no bubble.
    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        bus.decode_alloc_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.rob_retire       = 1'b1;
            bus.rob_retire_robid = 8'((k - 1) % 4);
            #1;
            checks++;
            if (bus.alloc_grant !== 1'b1 || bus.alloc_robid !== 8'(k % 4) || bus.rob_head !== 8'((k - 1) % 4) || bus.rob_count !== 9'd1) begin errors++; $display("FAIL b2b_%0d: got grant=%b id=%0d head=%0d count=%0d expected 1/%0d/%0d/1", k, bus.alloc_grant, bus.alloc_robid, bus.rob_head, bus.rob_count, k % 4, (k - 1) % 4); end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.alloc_error !== 1'b0 || bus.rob_head !== 8'd1 || bus.alloc_robid !== 8'd2) begin errors++; $display("FAIL b2b_end: got err=%b head=%0d tail=%0d expected 0/1/2", bus.alloc_error, bus.rob_head, bus.alloc_robid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.decode_alloc_req = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.rob_count !== 9'd3) begin errors++; $display("FAIL pre_async: got count=%0d expected 3", bus.rob_count); end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rob_count !== 9'd0 || bus.rob_head !== 8'd0 || bus.alloc_robid !== 8'd0 || bus.lsq_count !== 8'd0 || bus.alloc_error !== 1'b0) begin errors++; $display("FAIL async_reset: got count=%0d head=%0d tail=%0d lsq=%0d err=%b expected all 0", bus.rob_count, bus.rob_head, bus.alloc_robid, bus.lsq_count, bus.alloc_error); end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_fill_and_retire_full();
        test_lsq();
        test_flush();
        test_errors();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_alloc.md
# rob_alloc

ROB-tag and load/store-queue slot allocator sitting between decode and rename. Each cycle it grants decode at most one in-order ROB id and, for memory ops, one LSQ slot. It reclaims ids in order as the ROB retires and reclaims LSQ slots as the LSQ releases them. It discards all in-flight allocations on a ROB flush and raises a single stall that back-pressures decode when either resource is exhausted.

## Interface
Parameters:
- ROB_DEPTH, 64, ROB entries; power of two, 2..256
- LSQ_DEPTH, 16, LSQ entries; 1..255

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- decode_alloc_req  in  1  decode requests an id for the instruction presented this cycle
- decode_uses_memory  in  1  requesting instruction also needs an LSQ slot
- alloc_grant  out  1  allocation accepted this cycle
- alloc_robid  out  8  id granted; equals tail pointer, zero-extended
- alloc_stall  out  1  decode must hold its instruction
- rob_retire  in  1  ROB retires its head entry this cycle
- rob_retire_robid  in  8  id being retired; must equal rob_head
- lsq_release  in  1  LSQ frees one slot this cycle
- rob_flush  in  1  squash every allocated id
- rob_head  out  8  oldest allocated id
- rob_count  out  9  allocated ROB entries, 0..ROB_DEPTH
- lsq_count  out  8  allocated LSQ slots, 0..LSQ_DEPTH
- alloc_error  out  1  sticky protocol-violation flag

## Operation
- State:
  - head and tail are log2(ROB_DEPTH)-bit pointers and wrap modulo ROB_DEPTH.
  - rob_count and lsq_count are saturating-free counters; bounds are enforced by the logic below.
- rob_full = (rob_count == ROB_DEPTH). lsq_full = (lsq_count == LSQ_DEPTH).
- alloc_stall = decode_alloc_req & (rob_full | (decode_uses_memory & lsq_full) | rob_flush).
- alloc_grant = decode_alloc_req & ~alloc_stall.
- On grant:
  - tail advances by 1 and rob_count increments.
  - If decode_uses_memory is set, lsq_count also increments.
- Retire is legal when rob_count != 0 and rob_retire_robid == head. A legal retire advances head and decrements rob_count.
- A legal release (lsq_count != 0) decrements lsq_count.
- Same-cycle grant, retire and release all apply, so net counter change is the sum of the individual changes.
- Freed capacity is not bypassed. A retire in a full cycle does not unstall that cycle; the grant happens next cycle.
- Flush:
  - Any retire in the same cycle is applied first.
  - Next state: tail = new head, rob_count = 0, lsq_count = 0.
  - No grant occurs in a flush cycle. A lsq_release in a flush cycle is ignored.
- Errors: an illegal retire (empty ROB or id mismatch) or an illegal release is ignored and sets alloc_error.
  - alloc_error stays set until rst.
  - The legal parts of the same cycle still take effect.

## Timing
- Reset values: head = 0, tail = 0, rob_count = 0, lsq_count = 0, alloc_error = 0.
  - Resulting outputs: alloc_robid = 0, rob_head = 0, alloc_grant = 0, alloc_stall = 0.
- Asserting rst mid-operation clears all state immediately, independent of clk.
- alloc_grant, alloc_stall and alloc_robid are combinational from current state and same-cycle inputs. There is zero-cycle latency to decode.
- All counters and pointers change only at posedge. Outputs reflect a grant, retire, release or flush from the next cycle on.
- Wrap-around: after id ROB_DEPTH-1 the next id is 0, with no bubble.
- A stalled request repeated the following cycle is granted once capacity is visible.
- A request without decode_uses_memory is never stalled by lsq_full.

## Test plan
Bench parameters: ROB_DEPTH=4, LSQ_DEPTH=2.
- Reset, then request every cycle with no retire -> grants ids 0,1,2,3; cycle 5 alloc_stall=1, alloc_grant=0, rob_count=4.
- From full, retire id 0 while requesting -> no grant that cycle. Next cycle alloc_grant=1 with alloc_robid=0 (wrap) and rob_head=1.
- Three memory requests, no release -> first two granted, third stalls with lsq_count=2. A non-memory request in the same state is granted.
- Allocate ids 0..2, then flush with a retire of id 0 -> next cycle rob_head=1, alloc_robid=1, rob_count=0, lsq_count=0. The request in the flush cycle is stalled.
- Retire with robid 3 while head=0, and separately lsq_release at lsq_count=0 -> counts unchanged, alloc_error=1 and it stays set.
- Assert rst asynchronously between edges with rob_count=3 -> all outputs return to reset values before the next posedge.
